// File: rtl/histo_readout_sched.sv
// histo_readout_sched
//
// Reads histogram frames from NUM_CH channels and sends them to one shared
// word serializer. Round-robin arbitration picks the channel. Each frame is
// sent as a header word, then bins 0..NUM_BINS-1, then an optional checksum
// footer.
//
// Optional feature macro: HISTO_CHECKSUM_EN
//   defined   : a checksum accumulator, the FTR state and the footer word exist
//   undefined : frames end after the last bin (BINS -> DONE)
//
// Ports
//   fast_clk_in  in   sole clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   frame_req    in   [NUM_CH]      per-channel "frame ready" level
//   frame_ack    out  [NUM_CH]      one-cycle pulse when the granted frame is sent
//   ch_sel       out  [clog2 NUM_CH] granted channel, steers the bin RAM read mux
//   bin_addr     out  [BIN_ADDR_W]  bin RAM read address
//   bin_data     in   [32]          bin RAM data, valid one cycle after bin_addr
//   ser_data     out  [32]          registered word for the serializer
//   ser_reset    out  hold reset to the serializer (high in IDLE and DONE)
//   ser_done     in   serializer pulse, current word fully shifted out
//   busy         out  high whenever the FSM is not in IDLE
module histo_readout_sched #(
  parameter int          NUM_CH     = 4,
  parameter int          BIN_ADDR_W = 10,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
  input  logic                      fast_clk_in,
  input  logic                      reset_n,
  input  logic [NUM_CH-1:0]         frame_req,
  output logic [NUM_CH-1:0]         frame_ack,
  output logic [$clog2(NUM_CH)-1:0] ch_sel,
  output logic [BIN_ADDR_W-1:0]     bin_addr,
  input  logic [31:0]               bin_data,
  output logic [31:0]               ser_data,
  output logic                      ser_reset,
  input  logic                      ser_done,
  output logic                      busy
);

  localparam int                    CH_W       = $clog2(NUM_CH);
  localparam logic [BIN_ADDR_W-1:0] LAST_ADDR  = {BIN_ADDR_W{1'b1}};
  localparam logic [CH_W-1:0]       LAST_CH    = CH_W'(NUM_CH - 1);
  localparam logic [CH_W:0]         NUM_CH_EXT = (CH_W + 1)'(NUM_CH);

`ifdef HISTO_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, HDR, BINS, FTR, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, HDR, BINS, DONE} state_t;
`endif

  state_t                  state_reg;
  logic [CH_W-1:0]         ch_sel_reg;
  logic [CH_W-1:0]         rr_ptr_reg;
  logic [BIN_ADDR_W-1:0]   bin_addr_reg;
  logic [31:0]             ser_data_reg;
  logic [31:0]             prefetch_reg;
  logic                    pf_valid_reg;
  // bit0: address changed last edge; bit1: RAM data for it is now on bin_data
  logic [1:0]              fetch_pipe_reg;
  logic                    last_bin_reg;
  logic [15:0]             frame_cnt_reg;
  logic [NUM_CH-1:0]       frame_ack_reg;
  logic                    ser_reset_reg;
  logic                    busy_reg;
`ifdef HISTO_CHECKSUM_EN
  logic [31:0]             checksum_reg;
`endif

  // Requests rotated so that index 0 is the channel at rr_ptr; the lowest
  // set index of req_rot is then the round-robin winner.
  logic [NUM_CH-1:0]       req_rot;
  logic [CH_W-1:0]         rot_idx [NUM_CH];
  logic [NUM_CH-1:0]       ack_onehot;
  logic [CH_W-1:0]         grant_idx;
  logic [31:0]             header_word;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [CH_W:0] sum;
      assign sum          = {1'b0, rr_ptr_reg} + (CH_W + 1)'(gi);
      assign rot_idx[gi]  = (sum >= NUM_CH_EXT) ? CH_W'(sum - NUM_CH_EXT) : sum[CH_W-1:0];
      assign req_rot[gi]  = frame_req[rot_idx[gi]];
      assign ack_onehot[gi] = (ch_sel_reg == CH_W'(gi));
    end
  endgenerate

  always_comb begin
    grant_idx = rot_idx[0];
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req_rot[i]) grant_idx = rot_idx[i];
    end
  end

  assign header_word = {SYNC_BYTE, 5'b0, 3'(grant_idx), frame_cnt_reg};

  always_ff @(posedge fast_clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      ch_sel_reg     <= '0;
      rr_ptr_reg     <= '0;
      bin_addr_reg   <= '0;
      ser_data_reg   <= '0;
      prefetch_reg   <= '0;
      pf_valid_reg   <= 1'b0;
      fetch_pipe_reg <= '0;
      last_bin_reg   <= 1'b0;
      frame_cnt_reg  <= '0;
      frame_ack_reg  <= '0;
      ser_reset_reg  <= 1'b1;
      busy_reg       <= 1'b0;
`ifdef HISTO_CHECKSUM_EN
      checksum_reg   <= '0;
`endif
    end else begin
      frame_ack_reg  <= '0;
      fetch_pipe_reg <= {fetch_pipe_reg[0], 1'b0};
      if (fetch_pipe_reg[1]) begin
        prefetch_reg <= bin_data;
        pf_valid_reg <= 1'b1;
      end

      case (state_reg)
        IDLE: begin
          if (|frame_req) begin
            ch_sel_reg     <= grant_idx;
            ser_data_reg   <= header_word;
            bin_addr_reg   <= '0;
            last_bin_reg   <= 1'b0;
            pf_valid_reg   <= 1'b0;
            fetch_pipe_reg <= 2'b01;
            ser_reset_reg  <= 1'b0;
            busy_reg       <= 1'b1;
            state_reg      <= HDR;
`ifdef HISTO_CHECKSUM_EN
            checksum_reg   <= '0;
`endif
          end
        end

        HDR, BINS: begin
          if (ser_done) begin
            if (state_reg == BINS && last_bin_reg) begin
              // The last bin has just left the serializer.
`ifdef HISTO_CHECKSUM_EN
              ser_data_reg  <= checksum_reg;
              state_reg     <= FTR;
`else
              ser_reset_reg <= 1'b1;
              frame_ack_reg <= ack_onehot;
              state_reg     <= DONE;
`endif
            end else if (pf_valid_reg) begin
              ser_data_reg <= prefetch_reg;
              pf_valid_reg <= 1'b0;
`ifdef HISTO_CHECKSUM_EN
              checksum_reg <= checksum_reg + prefetch_reg;
`endif
              // Address holds on the last bin; no further fetch is issued.
              if (bin_addr_reg == LAST_ADDR) begin
                last_bin_reg <= 1'b1;
              end else begin
                bin_addr_reg   <= bin_addr_reg + 1'b1;
                fetch_pipe_reg <= 2'b01;
              end
              state_reg <= BINS;
            end
          end
        end

`ifdef HISTO_CHECKSUM_EN
        FTR: begin
          if (ser_done) begin
            ser_reset_reg <= 1'b1;
            frame_ack_reg <= ack_onehot;
            state_reg     <= DONE;
          end
        end
`endif

        DONE: begin
          frame_cnt_reg <= frame_cnt_reg + 16'd1;
          rr_ptr_reg    <= (ch_sel_reg == LAST_CH) ? '0 : ch_sel_reg + 1'b1;
          busy_reg      <= 1'b0;
          state_reg     <= IDLE;
        end

        default: begin
          ser_reset_reg <= 1'b1;
          busy_reg      <= 1'b0;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

  assign frame_ack = frame_ack_reg;
  assign ch_sel    = ch_sel_reg;
  assign bin_addr  = bin_addr_reg;
  assign ser_data  = ser_data_reg;
  assign ser_reset = ser_reset_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_histo_readout_sched.sv
// Scoreboard bench for histo_readout_sched (NUM_CH=4, BIN_ADDR_W=2).
// The driver pushes expected words/acks when it issues a request; the
// monitor pops and compares whenever the serializer model reports ser_done
// or the DUT pulses frame_ack.
module tb_histo_readout_sched;

  localparam int NUM_CH     = 4;
  localparam int BIN_ADDR_W = 2;
  localparam int NUM_BINS   = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  frame_req;
  logic [3:0]  frame_ack;
  logic [1:0]  ch_sel;
  logic [1:0]  bin_addr;
  logic [31:0] bin_data;
  logic [31:0] ser_data;
  logic        ser_reset;
  logic        ser_done;
  logic        busy;

  always #5 clk = ~clk;

  histo_readout_sched #(
    .NUM_CH     (NUM_CH),
    .BIN_ADDR_W (BIN_ADDR_W),
    .SYNC_BYTE  (8'hA5)
  ) dut (
    .fast_clk_in (clk),
    .reset_n     (reset_n),
    .frame_req   (frame_req),
    .frame_ack   (frame_ack),
    .ch_sel      (ch_sel),
    .bin_addr    (bin_addr),
    .bin_data    (bin_data),
    .ser_data    (ser_data),
    .ser_reset   (ser_reset),
    .ser_done    (ser_done),
    .busy        (busy)
  );

  // Bin RAM model: registered read, data one cycle after address.
  logic [31:0] mem [NUM_CH][NUM_BINS];
  always @(posedge clk) bin_data <= mem[ch_sel][bin_addr];

  // Serializer model: ser_done every 6 cycles while out of reset.
  int ser_cnt;
  always @(posedge clk) begin
    if (ser_reset) begin
      ser_cnt  <= 0;
      ser_done <= 1'b0;
    end else if (ser_cnt == 5) begin
      ser_cnt  <= 0;
      ser_done <= 1'b1;
    end else begin
      ser_cnt  <= ser_cnt + 1;
      ser_done <= 1'b0;
    end
  end

  logic [31:0] exp_words [$];
  logic [3:0]  exp_acks  [$];

  int vectors     = 0;
  int miscompares = 0;

  // Driver -> monitor request counters (each written by one process only).
  int reset_seq = 0;
  int to_cnt    = 0;
  int end_seq   = 0;
  int reset_seen = 0;
  int to_seen    = 0;
  int end_seen   = 0;
  logic [31:0] mon_w;
  logic [3:0]  mon_a;

  function automatic void cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end else begin
      $display("ok   %s: %h", nm, act);
    end
  endfunction

  always @(negedge clk) begin
    if (reset_seq != reset_seen && !reset_n) begin
      reset_seen = reset_seq;
      cmp("reset ser_reset", 32'(ser_reset), 32'd1);
      cmp("reset busy",      32'(busy),      32'd0);
      cmp("reset ser_data",  ser_data,       32'd0);
      cmp("reset bin_addr",  32'(bin_addr),  32'd0);
      cmp("reset ch_sel",    32'(ch_sel),    32'd0);
      cmp("reset frame_ack", 32'(frame_ack), 32'd0);
    end
    if (reset_n && ser_done) begin
      if (exp_words.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL word: unexpected ser_data %h, required no word", ser_data);
      end else begin
        mon_w = exp_words.pop_front();
        cmp("word", ser_data, mon_w);
      end
    end
    if (frame_ack != 4'b0) begin
      if (exp_acks.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL ack: unexpected frame_ack %b, required none", frame_ack);
      end else begin
        mon_a = exp_acks.pop_front();
        cmp("frame_ack", 32'(frame_ack), 32'(mon_a));
      end
    end
    if (to_cnt != to_seen) begin
      to_seen = to_cnt;
      vectors++;
      miscompares++;
      $display("FAIL timeout: wait expired, %0d words and %0d acks pending, required 0",
               exp_words.size(), exp_acks.size());
    end
    if (end_seq != end_seen) begin
      end_seen = end_seq;
      cmp("words left", 32'(exp_words.size()), 32'd0);
      cmp("acks left",  32'(exp_acks.size()),  32'd0);
    end
  end

  localparam int WPF =
`ifdef HISTO_CHECKSUM_EN
    NUM_BINS + 2;
`else
    NUM_BINS + 1;
`endif

  task automatic push_frame(input int ch, input logic [15:0] cnt);
    logic [31:0] sum;
    sum = 32'd0;
    exp_words.push_back({8'hA5, 5'b0, 3'(ch), cnt});
    for (int k = 0; k < NUM_BINS; k++) begin
      exp_words.push_back(mem[ch][k]);
      sum = sum + mem[ch][k];
    end
`ifdef HISTO_CHECKSUM_EN
    exp_words.push_back(sum);
`endif
    exp_acks.push_back(4'b0001 << ch);
  endtask

  task automatic wait_acks(input int n);
    int seen;
    int budget;
    seen = 0;
    budget = 0;
    while (seen < n && budget < 4000) begin
      @(negedge clk);
      budget++;
      if (frame_ack != 4'b0) seen++;
    end
    if (seen < n) to_cnt++;
  endtask

  task automatic wait_left(input int n);
    int budget;
    budget = 0;
    while (exp_words.size() > n && budget < 4000) begin
      @(negedge clk);
      budget++;
    end
    if (exp_words.size() > n) to_cnt++;
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    reset_seq++;
    exp_words.delete();
    exp_acks.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n   = 1'b1;
    frame_req = 4'b0;
    for (int c = 0; c < NUM_CH; c++)
      for (int k = 0; k < NUM_BINS; k++)
        mem[c][k] = 32'h1000_0000 * c + 32'h11 * (k + 1);
    for (int k = 0; k < NUM_BINS; k++) mem[1][k] = 32'(k + 1);
    for (int k = 0; k < NUM_BINS; k++) mem[3][k] = 32'hFFFF_FFFF;

    #2 reset_n = 1'b0;
    reset_seq++;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Single frame, ch1, bins 1..4: A5010000,1,2,3,4,(0000000A)
    push_frame(1, 16'h0000);
    frame_req = 4'b0010;
    wait_acks(1);
    frame_req = 4'b0;

    // All channels requesting from reset: grant order 0,1,2,3
    pulse_reset();
    for (int c = 0; c < 4; c++) push_frame(c, 16'(c));
    frame_req = 4'b1111;
    wait_acks(4);
    frame_req = 4'b0;

    // Granted channel drops its request after the header
    push_frame(2, 16'd4);
    frame_req = 4'b0100;
    wait_left(WPF - 1);
    frame_req = 4'b0;
    wait_acks(1);

    // All-ones bins: footer FFFFFFFC (if enabled)
    push_frame(3, 16'd5);
    frame_req = 4'b1000;
    wait_acks(1);
    frame_req = 4'b0;

    // Reset in the middle of BINS: frame abandoned, restart with frame_cnt 0
    push_frame(0, 16'd6);
    frame_req = 4'b0001;
    wait_left(WPF - 3);
    pulse_reset();
    push_frame(0, 16'd0);
    wait_acks(1);
    frame_req = 4'b0;

    // frame_cnt wrap FFFF -> 0000
    @(negedge clk);
    force dut.frame_cnt_reg = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt_reg;
    push_frame(1, 16'hFFFF);
    push_frame(1, 16'h0000);
    frame_req = 4'b0010;
    wait_acks(2);
    frame_req = 4'b0;

    repeat (3) @(negedge clk);
    end_seq++;
    repeat (2) @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/histo_readout_sched.md
HISTO_READOUT_SCHED -- requirements
Module: histo_readout_sched

Interface
REQ-001 Parameter: NUM_CH, 4, number of histogram channels sharing one serializer (2..8).
REQ-002 Parameter: BIN_ADDR_W, 10, bin address width; NUM_BINS = 2**BIN_ADDR_W.
REQ-003 Parameter: SYNC_BYTE, 8'hA5, header marker byte.
REQ-004 Port: fast_clk_in  input  1  sole clock, rising edge.
REQ-005 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-006 Port: frame_req  input  NUM_CH  per-channel level, frame ready for readout.
REQ-007 Port: frame_ack  output  NUM_CH  one-cycle pulse, granted channel's frame fully sent.
REQ-008 Port: ch_sel  output  clog2(NUM_CH)  granted channel; selects the bin RAM read mux.
REQ-009 Port: bin_addr  output  BIN_ADDR_W  bin RAM read address.
REQ-010 Port: bin_data  input  32  bin RAM read data, valid one cycle after bin_addr.
REQ-011 Port: ser_data  output  32  word to serializer data_in; registered.
REQ-012 Port: ser_reset  output  1  active-high hold reset to serializer.
REQ-013 Port: ser_done  input  1  serializer pulse, last byte of current word shifted out.
REQ-014 Port: busy  output  1  high in any state other than IDLE.

Function
REQ-015 FSM states are IDLE, HDR, BINS, FTR and DONE; ser_reset SHALL be 1 in IDLE and DONE and 0 otherwise.
REQ-016 IDLE: when any frame_req bit is high, round-robin arbitration picks the first requester at or after rr_ptr (wrapping), latches ch_sel, and moves to HDR on the same edge.
REQ-017 Entering HDR: ser_data = {SYNC_BYTE, 5'b0, ch_sel zero-extended to 3 bits, frame_cnt[15:0]}, bin_addr = 0, checksum = 0.
REQ-018 A 32-bit prefetch register captures bin_data on the second edge after each bin_addr change; a prefetch-valid flag tracks that capture.
REQ-019 HDR: on ser_done, ser_data loads the prefetch register on that edge (one-cycle latency), checksum += that word mod 2^32, bin_addr increments, and the state moves to BINS.
REQ-020 BINS: on each ser_done, the next prefetched bin is loaded in the same way, except after the bin at address NUM_BINS-1: then go to FTR with checksum in ser_data if HISTO_CHECKSUM_EN, else go to DONE.
REQ-021 FTR: on ser_done, go to DONE.
REQ-022 DONE, lasting one cycle: frame_ack[ch_sel] = 1, frame_cnt increments (16-bit, wraps FFFF->0000), rr_ptr = ch_sel+1 mod NUM_CH, then go to IDLE.
REQ-023 Each frame SHALL contain exactly 1 + NUM_BINS (+1 with checksum) words, in the order header, bins 0..NUM_BINS-1, footer.
REQ-024 Dropping frame_req of the granted channel mid-frame SHALL NOT abort the frame; other channels' requests SHALL wait until IDLE.
REQ-025 ser_done in IDLE or DONE, or with prefetch-valid low, SHALL be ignored.
REQ-026 bin_addr SHALL NOT wrap within a frame; it holds at NUM_BINS-1 after the last fetch.

Reset
REQ-027 With reset_n low: state = IDLE, ser_reset = 1, ser_data = 0, bin_addr = 0, ch_sel = 0, rr_ptr = 0, frame_cnt = 0, checksum = 0, frame_ack = 0, busy = 0, prefetch-valid = 0.
REQ-028 Reset mid-frame SHALL abandon the frame without frame_ack; after release, a channel still requesting SHALL restart from the header.

Configuration
REQ-029 Macro HISTO_CHECKSUM_EN defined: checksum accumulator, FTR state and footer word are present.
REQ-030 Macro HISTO_CHECKSUM_EN undefined: no accumulator and no FTR state; BINS goes directly to DONE.

Verification
REQ-031 NUM_CH=4, BIN_ADDR_W=2, frame_req=4'b0010, bins 1,2,3,4, checksum on -> ser_data sequence A5010000, 1, 2, 3, 4, 0000000A; one frame_ack=4'b0010 pulse.
REQ-032 frame_req=4'b1111 held through four frames from reset -> grant order 0,1,2,3 and header frame_cnt fields 0,1,2,3.
REQ-033 Mid-BINS reset_n pulse -> ser_reset=1 immediately, no frame_ack; after release with the request held -> new header with frame_cnt=0.
REQ-034 Granted channel drops frame_req after the header -> all 6 words still sent, then frame_ack.
REQ-035 Checksum off, bins FFFFFFFF x4 -> 5 words, no footer; checksum on -> footer FFFFFFFC.
REQ-036 Force frame_cnt=FFFF -> header low half FFFF, next frame's header low half 0000.
